// File: rtl/otter_iobus_arbiter.sv
// otter_iobus_arbiter
//   Two-master round-robin arbiter and transaction sequencer for the OTTER
//   memory-mapped I/O bus. Master 0 is the hart data port, master 1 a second
//   bus master (DMA/debug). One transaction is in flight at a time; the bus
//   is held until the peripheral acknowledges or TIMEOUT cycles elapse.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_mN_req/we/sel/addr/w_data   master N request and its payload
//   o_mN_gnt                  combinational accept pulse (IDLE only)
//   o_mN_done/err/r_data      registered completion, timeout flag, read data
//   o_iobus_re/we/sel/addr/data   registered shared bus outputs
//   i_iobus_data, i_iobus_ack     peripheral response
module otter_iobus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_w_data,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic        o_m0_err,
  output logic [31:0] o_m0_r_data,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_w_data,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic        o_m1_err,
  output logic [31:0] o_m1_r_data,
  output logic        o_iobus_re,
  output logic        o_iobus_we,
  output logic [3:0]  o_iobus_sel,
  output logic [31:0] o_iobus_addr,
  output logic [31:0] o_iobus_data,
  input  logic [31:0] i_iobus_data,
  input  logic        i_iobus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic          owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          bus_re_nxt, bus_we_nxt;
  logic [3:0]    bus_sel_nxt;
  logic [31:0]   bus_addr_nxt, bus_data_nxt;

  logic          m0_done_nxt, m0_err_nxt, m1_done_nxt, m1_err_nxt;
  logic [31:0]   m0_r_nxt, m1_r_nxt;

  logic          grant;
  logic          win;

  // Arbitration: a lone requester wins; on contention the master that did
  // not win last time gets the bus. No grant while reset is asserted.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (state == IDLE && !i_rst) begin
      if (i_m0_req && i_m1_req) begin
        grant = 1'b1;
        win   = ~last;
      end else if (i_m0_req) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (i_m1_req) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  assign o_m0_gnt = grant & ~win;
  assign o_m1_gnt = grant & win;

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    bus_re_nxt   = o_iobus_re;
    bus_we_nxt   = o_iobus_we;
    bus_sel_nxt  = o_iobus_sel;
    bus_addr_nxt = o_iobus_addr;
    bus_data_nxt = o_iobus_data;
    m0_done_nxt  = 1'b0;
    m1_done_nxt  = 1'b0;
    m0_err_nxt   = o_m0_err;
    m1_err_nxt   = o_m1_err;
    m0_r_nxt     = o_m0_r_data;
    m1_r_nxt     = o_m1_r_data;

    case (state)
      IDLE: begin
        if (grant) begin
          bus_we_nxt   = win ? i_m1_we     : i_m0_we;
          bus_re_nxt   = win ? ~i_m1_we    : ~i_m0_we;
          bus_sel_nxt  = win ? i_m1_sel    : i_m0_sel;
          bus_addr_nxt = win ? i_m1_addr   : i_m0_addr;
          bus_data_nxt = win ? i_m1_w_data : i_m0_w_data;
          last_nxt     = win;
          owner_nxt    = win;
          cnt_nxt      = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (i_iobus_ack || cnt == CNT_LAST) begin
          if (owner) begin
            m1_done_nxt = 1'b1;
            m1_err_nxt  = ~i_iobus_ack;
            if (!i_iobus_ack)   m1_r_nxt = '0;
            else if (o_iobus_re) m1_r_nxt = i_iobus_data;
          end else begin
            m0_done_nxt = 1'b1;
            m0_err_nxt  = ~i_iobus_ack;
            if (!i_iobus_ack)   m0_r_nxt = '0;
            else if (o_iobus_re) m0_r_nxt = i_iobus_data;
          end
          bus_re_nxt   = 1'b0;
          bus_we_nxt   = 1'b0;
          bus_sel_nxt  = '0;
          bus_addr_nxt = '0;
          bus_data_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      cnt          <= '0;
      o_iobus_re   <= 1'b0;
      o_iobus_we   <= 1'b0;
      o_iobus_sel  <= '0;
      o_iobus_addr <= '0;
      o_iobus_data <= '0;
      o_m0_done    <= 1'b0;
      o_m0_err     <= 1'b0;
      o_m0_r_data  <= '0;
      o_m1_done    <= 1'b0;
      o_m1_err     <= 1'b0;
      o_m1_r_data  <= '0;
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      owner        <= owner_nxt;
      cnt          <= cnt_nxt;
      o_iobus_re   <= bus_re_nxt;
      o_iobus_we   <= bus_we_nxt;
      o_iobus_sel  <= bus_sel_nxt;
      o_iobus_addr <= bus_addr_nxt;
      o_iobus_data <= bus_data_nxt;
      o_m0_done    <= m0_done_nxt;
      o_m0_err     <= m0_err_nxt;
      o_m0_r_data  <= m0_r_nxt;
      o_m1_done    <= m1_done_nxt;
      o_m1_err     <= m1_err_nxt;
      o_m1_r_data  <= m1_r_nxt;
    end
  end

endmodule

// File: tb/tb_otter_iobus_arbiter.sv
// Randomized bench for otter_iobus_arbiter: a transaction-level model picks
// each grant, the peripheral delay and read data, and queues the expected
// grant and completion; a separate monitor pops and compares.
module tb_otter_iobus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_m0_gnt, o_m0_done, o_m0_err, o_m1_gnt, o_m1_done, o_m1_err;
  logic [31:0] o_m0_r_data, o_m1_r_data;
  logic        o_iobus_re, o_iobus_we;
  logic [3:0]  o_iobus_sel;
  logic [31:0] o_iobus_addr, o_iobus_data;
  logic [31:0] i_iobus_data;
  logic        i_iobus_ack;

  logic        req_v  [2];
  logic        we_v   [2];
  logic [3:0]  sel_v  [2];
  logic [31:0] addr_v [2];
  logic [31:0] wd_v   [2];

  otter_iobus_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(req_v[0]), .i_m0_we(we_v[0]), .i_m0_sel(sel_v[0]),
    .i_m0_addr(addr_v[0]), .i_m0_w_data(wd_v[0]),
    .o_m0_gnt(o_m0_gnt), .o_m0_done(o_m0_done), .o_m0_err(o_m0_err),
    .o_m0_r_data(o_m0_r_data),
    .i_m1_req(req_v[1]), .i_m1_we(we_v[1]), .i_m1_sel(sel_v[1]),
    .i_m1_addr(addr_v[1]), .i_m1_w_data(wd_v[1]),
    .o_m1_gnt(o_m1_gnt), .o_m1_done(o_m1_done), .o_m1_err(o_m1_err),
    .o_m1_r_data(o_m1_r_data),
    .o_iobus_re(o_iobus_re), .o_iobus_we(o_iobus_we), .o_iobus_sel(o_iobus_sel),
    .o_iobus_addr(o_iobus_addr), .o_iobus_data(o_iobus_data),
    .i_iobus_data(i_iobus_data), .i_iobus_ack(i_iobus_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int m; int cyc; } gnt_t;
  typedef struct { int m; int cyc; logic err; logic [31:0] rd; } done_t;
  gnt_t  gq[$];
  done_t dq[$];

  // transaction-level model state
  int          last_m, busy_end, act_lo, act_hi, ack_cyc;
  logic [31:0] ack_dat;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wd;
  logic [31:0] rm  [2];
  logic [31:0] vis [2];
  bit          granted [2];
  bit          running;

  int chk = 0;
  int fails = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    gq.delete();
    dq.delete();
    last_m   = 1;
    busy_end = 0;
    act_lo   = -10;
    act_hi   = -10;
    ack_cyc  = -1;
    for (int m = 0; m < 2; m++) begin
      rm[m]      = '0;
      vis[m]     = '0;
      granted[m] = 1'b0;
    end
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_ctl"}, 64'({o_iobus_re, o_iobus_we, o_iobus_sel}), 64'(0));
    check({nm, "_addr"}, 64'(o_iobus_addr), 64'(0));
    check({nm, "_data"}, 64'(o_iobus_data), 64'(0));
    check({nm, "_flags"}, 64'({o_m0_gnt, o_m0_done, o_m0_err, o_m1_gnt, o_m1_done, o_m1_err}), 64'(0));
    check({nm, "_rd0"}, 64'(o_m0_r_data), 64'(0));
    check({nm, "_rd1"}, 64'(o_m1_r_data), 64'(0));
  endtask

  task automatic rand_req(int m);
    req_v[m]  = 1'b1;
    we_v[m]   = 1'($urandom_range(0, 1));
    sel_v[m]  = 4'($urandom);
    addr_v[m] = $urandom;
    wd_v[m]   = $urandom;
  endtask

  // Reference model: one transaction at a time, round-robin on contention.
  initial begin
    int w, d, done_c;
    logic err;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      granted[0] = 1'b0;
      granted[1] = 1'b0;
      if (!rst && cyc >= busy_end) begin
        w = -1;
        if (req_v[0] && req_v[1]) w = (last_m == 1) ? 0 : 1;
        else if (req_v[0])        w = 0;
        else if (req_v[1])        w = 1;
        if (w >= 0) begin
          gq.push_back('{w, cyc});
          granted[w] = 1'b1;
          last_m = w;
          e_we   = we_v[w];
          e_sel  = sel_v[w];
          e_addr = addr_v[w];
          e_wd   = wd_v[w];
          d = $urandom_range(0, TO + 1);
          if (d < TO) begin
            ack_cyc = cyc + 1 + d;
            ack_dat = $urandom;
            done_c  = cyc + 2 + d;
            err     = 1'b0;
            rd      = e_we ? rm[w] : ack_dat;
          end else begin
            ack_cyc = -1;
            done_c  = cyc + 1 + TO;
            err     = 1'b1;
            rd      = '0;
          end
          rm[w]    = rd;
          act_lo   = cyc + 1;
          act_hi   = done_c - 1;
          busy_end = done_c;
          dq.push_back('{w, done_c, err, rd});
        end
      end
    end
  end

  // Master and peripheral drivers.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        for (int m = 0; m < 2; m++) begin
          if (!req_v[m] || granted[m]) begin
            if ($urandom_range(0, 3) != 0) rand_req(m);
            else req_v[m] = 1'b0;
          end
        end
      end
      if (cyc == ack_cyc) begin
        i_iobus_ack  = 1'b1;
        i_iobus_data = ack_dat;
      end else begin
        i_iobus_data = $urandom;
        // spurious acks only where the model says the FSM is idle
        i_iobus_ack  = !(cyc >= act_lo && cyc <= act_hi) && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor.
  initial begin
    gnt_t  ge;
    done_t de;
    int    dm;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (o_m0_gnt || o_m1_gnt) begin
          if (gq.size() == 0) check("gnt_unexpected", 64'({o_m1_gnt, o_m0_gnt}), 64'(0));
          else begin
            ge = gq.pop_front();
            check("gnt_who", 64'({o_m1_gnt, o_m0_gnt}), 64'(ge.m ? 2 : 1));
            check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
          end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          ge = gq.pop_front();
          check("gnt_missing", 64'(0), 64'(ge.m + 1));
        end

        if (o_m0_done || o_m1_done) begin
          dm = o_m1_done ? 1 : 0;
          if (dq.size() == 0) check("done_unexpected", 64'({o_m1_done, o_m0_done}), 64'(0));
          else begin
            de = dq.pop_front();
            check("done_who", 64'({o_m1_done, o_m0_done}), 64'(de.m ? 2 : 1));
            check("done_cycle", 64'(cyc), 64'(de.cyc));
            check("done_err", 64'(dm ? o_m1_err : o_m0_err), 64'(de.err));
            vis[de.m] = de.rd;
          end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
          de = dq.pop_front();
          check("done_missing", 64'(0), 64'(de.m + 1));
          vis[de.m] = de.rd;
        end

        check("r_data0", 64'(o_m0_r_data), 64'(vis[0]));
        check("r_data1", 64'(o_m1_r_data), 64'(vis[1]));

        if (cyc >= act_lo && cyc <= act_hi) begin
          check("bus_ctl", 64'({o_iobus_re, o_iobus_we, o_iobus_sel}), 64'({~e_we, e_we, e_sel}));
          check("bus_addr", 64'(o_iobus_addr), 64'(e_addr));
          check("bus_data", 64'(o_iobus_data), 64'(e_wd));
        end else begin
          check("bus_idle_ctl", 64'({o_iobus_re, o_iobus_we, o_iobus_sel}), 64'(0));
          check("bus_idle_addr", 64'(o_iobus_addr), 64'(0));
          check("bus_idle_data", 64'(o_iobus_data), 64'(0));
        end
      end
    end
  end

  initial begin
    bit found;
    rst          = 1'b1;
    running      = 1'b0;
    i_iobus_ack  = 1'b0;
    i_iobus_data = '0;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; we_v[m] = 1'b0; sel_v[m] = '0; addr_v[m] = '0; wd_v[m] = '0;
    end
    model_reset();

    // reset values, with both masters already requesting
    repeat (2) @(posedge clk);
    rand_req(0);
    rand_req(1);
    @(negedge clk);
    #1;
    check_all_zero("reset");

    @(posedge clk);
    #1;
    rst     = 1'b0;
    running = 1'b1;
    repeat (3000) @(posedge clk);

    // reset while a transaction is waiting on the bus
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cyc >= act_lo && cyc < act_hi) found = 1'b1;
    end
    check("busy_wait", 64'(found), 64'(1));
    #2;
    running = 1'b0;
    rst     = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    rand_req(0);
    rand_req(1);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst     = 1'b0;
    running = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_first_m0", 64'({o_m1_gnt, o_m0_gnt}), 64'(1));

    repeat (300) @(posedge clk);
    #2;
    running  = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    for (int i = 0; i < 30 && (dq.size() > 0 || gq.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    #2;
    check("drain", 64'(dq.size() + gq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule

// File: doc/otter_iobus_arbiter.md
# otter_iobus_arbiter

Two-master arbiter and transaction sequencer for the OTTER memory-mapped I/O bus. Master 0 is the hart's data port (after the address-bit-31 decode steers it to I/O). Master 1 is a second bus master such as a DMA or debug unit. The block grants one master at a time with round-robin fairness, drives the shared I/O bus, waits for a peripheral acknowledge with a timeout, and returns read data, completion and error per master.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait in BUSY for `i_iobus_ack` before aborting with error; valid range 1..65535.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_mN_req  in  1  master N (N = 0, 1) requests a transaction; held until granted.
- i_mN_we  in  1  1 = write, 0 = read.
- i_mN_sel  in  4  byte lanes.
- i_mN_addr  in  32  byte address.
- i_mN_w_data  in  32  write data.
- o_mN_gnt  out  1  request accepted this cycle; master may change or drop its inputs next cycle.
- o_mN_done  out  1  one-cycle completion pulse.
- o_mN_err  out  1  valid with done; 1 = timed out.
- o_mN_r_data  out  32  read data, valid with done; held until the next done to that master.
- o_iobus_re  out  1  read strobe, held for the whole transaction.
- o_iobus_we  out  1  write strobe, held for the whole transaction.
- o_iobus_sel  out  4  byte lanes.
- o_iobus_addr  out  32  address.
- o_iobus_data  out  32  write data.
- i_iobus_data  in  32  peripheral read data, sampled on the ack cycle.
- i_iobus_ack  in  1  peripheral completes the transaction.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - If any `i_mN_req` is high, select a winner and assert its `o_mN_gnt` combinationally in the same cycle.
  - Register the winner's we/sel/addr/w_data onto the bus outputs. Drive `o_iobus_re` = !we and `o_iobus_we` = we.
  - Record owner and set `last` to the winner. Clear the wait counter. Go to BUSY.
- Arbitration:
  - Only one request: that master wins.
  - Both requesting: the master that is not `last` wins.
  - `last` resets to 1, so master 0 wins the first contention.
- BUSY:
  - Bus outputs are held constant. No gnt is asserted. New requests wait.
  - On `i_iobus_ack`:
    - Capture `i_iobus_data` into the owner's r_data on reads.
    - On writes, the owner's r_data is unchanged.
    - Pulse the owner's done with err=0. Clear all bus outputs to 0. Go to IDLE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 without ack:
    - Pulse the owner's done with err=1. Write the owner's r_data to 0 (reads and writes).
    - Clear bus outputs. Go to IDLE.
  - Ack in the same cycle as the timeout: ack wins, err=0.
- `i_iobus_ack` in IDLE is ignored.
- Only the owning master's done/err/r_data change. The other master's outputs are untouched.
- Counter width is ceil(log2(TIMEOUT+1)) bits and never wraps.

## Timing
- Reset values (asynchronous):
  - State IDLE, `last` = 1, counter 0.
  - All o_iobus_* = 0; all o_mN_done, o_mN_err, o_mN_r_data = 0.
  - `o_mN_gnt` = 0 while i_rst is high.
- Grant in cycle N:
  - Bus outputs valid from N+1.
  - Earliest ack is sampled at N+1.
  - done/err/r_data are registered and appear at N+2, the same cycle the FSM is back in IDLE.
- Minimum latency is 2 cycles from grant to done.
- The next grant can occur in the same cycle as the previous done, giving 1 transaction per 2 cycles at best.
- Timeout: with no ack, done (err=1) appears at N+1+TIMEOUT. The last bus-active cycle is N+TIMEOUT.
- `o_mN_gnt` is a single-cycle pulse. If the master holds req after gnt, that is a new request, eligible once the FSM is in IDLE.
- Reset mid-BUSY: the transaction is abandoned with no done pulse, and bus strobes drop immediately.

## Test plan
- Single read, m0 requests addr 0x0000_1000 sel 4'hF, ack at N+1 with data 0xCAFE_F00D -> m0_gnt at N; bus re=1, addr 0x1000 at N+1; m0_done=1, err=0, r_data=0xCAFE_F00D at N+2.
- Contention: both masters hold req continuously after reset, peripheral acks immediately -> grants alternate m0, m1, m0, m1; each done follows its own grant by 2 cycles.
- Write, m1 writes 0x1234_5678 sel 4'h3 to 0x0000_0040, ack delayed 5 cycles -> bus we=1, data and sel held stable for 6 cycles; m1_done at grant+7; m1 r_data unchanged.
- Timeout with TIMEOUT=4, read from m0, no ack -> bus active 4 cycles; m0_done=1, err=1, r_data=0 at grant+5; FSM accepts a new request the same cycle.
- Ack coincident with the last timeout cycle, and a spurious ack in IDLE -> err=0 with data captured; the IDLE ack causes no done and no state change.
- Assert i_rst while BUSY waiting for ack -> all outputs 0 asynchronously, no done pulse; after release, a pending m0 and m1 contention grants m0 first.
